flag_branch_reg: RTL

FLAG_BRANCH_REG -- requirements
Module: flag_branch_reg

---
 rtl/flag_branch_reg_pkg.sv | 50 +++++
 rtl/flag_branch_reg_if.sv | 32 +++
 rtl/flag_branch_reg_cond_eval.sv | 31 +++
 rtl/flag_branch_reg.sv | 78 +++++++
 4 files changed

// File: rtl/flag_branch_reg_pkg.sv
// Shared definitions for the flag/branch EX->MEM stage: flag bit positions,
// branch condition codes, opcode constants and the registered MEM record.
package flag_branch_reg_pkg;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    COND_NEQ    = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } cond_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_CMP  = 4'h9,
    OP_LDI  = 4'hA,
    OP_LD   = 4'hB,
    OP_ST   = 4'hC,
    OP_BR   = 4'hD,
    OP_JMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] alu_out;
    logic [3:0]  dst;
    logic        wr_en;
    logic        br_taken;
  } mem_stage_t;

  localparam mem_stage_t MEM_RESET = '{valid: 1'b0, alu_out: 16'h0000, dst: 4'h0,
                                       wr_en: 1'b0, br_taken: 1'b0};

endpackage

// File: rtl/flag_branch_reg_if.sv
// EX-side request and MEM-side result bundle of the flag/branch stage.
interface flag_branch_reg_if;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [15:0] ex_alu_out;
  logic [2:0]  ex_flags;
  logic [2:0]  ex_flag_en;
  logic [3:0]  ex_dst;
  logic        ex_wr_en;
  logic        ex_is_branch;
  logic [2:0]  ex_cond;
  logic [2:0]  flags_q;
  logic        br_taken;
  logic        mem_valid;
  logic [15:0] mem_alu_out;
  logic [3:0]  mem_dst;
  logic        mem_wr_en;
  logic        mem_br_taken;

  modport master (
    output stall, flush, ex_valid, ex_alu_out, ex_flags, ex_flag_en, ex_dst,
           ex_wr_en, ex_is_branch, ex_cond,
    input  flags_q, br_taken, mem_valid, mem_alu_out, mem_dst, mem_wr_en, mem_br_taken
  );

  modport slave (
    input  stall, flush, ex_valid, ex_alu_out, ex_flags, ex_flag_en, ex_dst,
           ex_wr_en, ex_is_branch, ex_cond,
    output flags_q, br_taken, mem_valid, mem_alu_out, mem_dst, mem_wr_en, mem_br_taken
  );
endinterface

// File: rtl/flag_branch_reg_cond_eval.sv
// Branch condition evaluator: maps a condition code and {Z,V,N} to taken/not-taken.
module cond_eval
  import flag_branch_reg_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       true
);

  logic z, v, n;
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    // NOTE: default assigned before the case so no path leaves 'true' unassigned (no latch).
    true = 1'b0;
    case (cond_e'(cond))
      COND_NEQ:    true = ~z;
      COND_EQ:     true = z;
      COND_GT:     true = ~z & ~n;
      COND_LT:     true = n;
      COND_GTE:    true = z | (~z & ~n);
      COND_LTE:    true = n | z;
      COND_OVFL:   true = v;
      COND_UNCOND: true = 1'b1;
      default:     true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_reg.sv
// EX->MEM pipeline register with the architectural {Z,V,N} flag register and
// a combinational branch decision based on flags from older instructions only.
module flag_branch_reg
  import flag_branch_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_out,
  input  logic [2:0]  ex_flags,
  input  logic [2:0]  ex_flag_en,
  input  logic [3:0]  ex_dst,
  input  logic        ex_wr_en,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_cond,
  output logic [2:0]  flags_q,
  output logic        br_taken,
  output logic        mem_valid,
  output logic [15:0] mem_alu_out,
  output logic [3:0]  mem_dst,
  output logic        mem_wr_en,
  output logic        mem_br_taken
);

  logic       adv;
  logic       bubble;
  logic       cond_true;
  logic [2:0] flag_mask;
  mem_stage_t mem_q;

  assign adv       = ex_valid & ~stall & ~flush;
  // Flush wins over stall; an empty EX slot only bubbles when the stage is moving.
  assign bubble    = flush | (~ex_valid & ~stall);
  assign flag_mask = {3{adv}} & ex_flag_en;

  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (ex_cond),
    .true  (cond_true)
  );

  assign br_taken = ex_valid & ex_is_branch & cond_true & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      // NOTE: non-blocking assignment for all sequential state avoids read/write races between blocks.
      flags_q <= (flags_q & ~flag_mask) | (ex_flags & flag_mask);
    end
  end

  // Bubbles clear only the control bits; payload keeps its stale value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= MEM_RESET;
    end else if (bubble) begin
      mem_q.valid    <= 1'b0;
      mem_q.wr_en    <= 1'b0;
      mem_q.br_taken <= 1'b0;
    end else if (adv) begin
      mem_q.valid    <= 1'b1;
      mem_q.alu_out  <= ex_alu_out;
      mem_q.dst      <= ex_dst;
      mem_q.wr_en    <= ex_wr_en;
      mem_q.br_taken <= br_taken;
    end
  end

  assign mem_valid    = mem_q.valid;
  assign mem_alu_out  = mem_q.alu_out;
  assign mem_dst      = mem_q.dst;
  assign mem_wr_en    = mem_q.wr_en;
  assign mem_br_taken = mem_q.br_taken;

endmodule
